// File: rtl/ad7864_pkg.sv
// Shared types and widths for the AD7864 read sequencer.
package ad7864_pkg;

  localparam int ADC_W = 12;
  localparam int OUT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_SETUP,
    S_RD,
    S_RECOV
  } seq_state_e;

endpackage

// File: rtl/ad7864_rd_seq_sync2ff.sv
// Two-flop synchronizer for the asynchronous BUSY input.
module sync2ff (
  input  logic clkin,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ad7864_rd_seq.sv
// Reads NCH channels from each of NCHIP AD7864s after every conversion, one word per read.
// Define AD7864_RD_SEQ_TAG_EN to carry {chip,channel} in out_data[15:12].
module ad7864_rd_seq
  import ad7864_pkg::*;
#(
  parameter int NCHIP       = 4,
  parameter int NCH         = 4,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             busy,
  input  logic [ADC_W-1:0] db,
  output logic [NCHIP-1:0] cs_bar,
  output logic             rd_bar,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             overrun
);

  localparam int CHIP_W  = (NCHIP > 4) ? $clog2(NCHIP) : 2;
  localparam int CH_W    = (NCH > 4) ? $clog2(NCH) : 2;
  localparam int TMR_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(NCHIP - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);
  localparam logic [TMR_W-1:0]  TMR_LOW   = TMR_W'(RD_LOW_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_HIGH  = TMR_W'(RD_HIGH_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [CHIP_W-1:0] chip_q, chip_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADC_W-1:0]  samp_q, samp_d;
  logic [NCHIP-1:0]  cs_bar_q, cs_bar_d;
  logic              rd_bar_q, rd_bar_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              busy_s, busy_s_q, busy_rise;
  logic [OUT_W-1:0]  word;

  sync2ff u_busy_sync (
    .clkin (clkin),
    .rst   (rst),
    .d_i   (busy),
    .q_o   (busy_s)
  );

  assign busy_rise = busy_s & ~busy_s_q;

`ifdef AD7864_RD_SEQ_TAG_EN
  assign word = {chip_q[1:0], ch_q[1:0], samp_q};
`else
  assign word = {{(OUT_W - ADC_W){1'b0}}, samp_q};
`endif

  always_comb begin
    state_d      = state_q;
    chip_d       = chip_q;
    ch_d         = ch_q;
    tmr_d        = tmr_q;
    samp_d       = samp_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~out_ready;
    frame_done_d = 1'b0;
    // A new conversion during a read burst is flagged but never read.
    overrun_d    = overrun_q | (busy_rise & (state_q inside {S_SETUP, S_RD, S_RECOV}));

    case (state_q)
      S_IDLE: if (busy_s) state_d = S_CONV;
      S_CONV: begin
        if (!busy_s) begin
          state_d = S_SETUP;
          chip_d  = '0;
          ch_d    = '0;
        end
      end
      S_SETUP: begin
        state_d = S_RD;
        tmr_d   = TMR_LOW;
      end
      S_RD: begin
        if (tmr_q == '0) begin
          samp_d  = db;
          state_d = S_RECOV;
          tmr_d   = TMR_HIGH;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RECOV: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (!out_valid_q || out_ready) begin
          out_data_d  = word;
          out_valid_d = 1'b1;
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_RD;
            tmr_d   = TMR_LOW;
          end else if (chip_q != CHIP_LAST) begin
            chip_d  = chip_q + CHIP_W'(1);
            ch_d    = '0;
            state_d = S_SETUP;
          end else begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so the ADC pins never glitch.
    rd_bar_d = (state_d != S_RD);
    cs_bar_d = '1;
    if (state_d inside {S_SETUP, S_RD, S_RECOV}) cs_bar_d = ~(NCHIP'(1) << chip_d);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chip_q       <= '0;
      ch_q         <= '0;
      tmr_q        <= '0;
      samp_q       <= '0;
      cs_bar_q     <= '1;
      rd_bar_q     <= 1'b1;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      chip_q       <= chip_d;
      ch_q         <= ch_d;
      tmr_q        <= tmr_d;
      samp_q       <= samp_d;
      cs_bar_q     <= cs_bar_d;
      rd_bar_q     <= rd_bar_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      busy_s_q     <= busy_s;
    end
  end

  assign cs_bar     = cs_bar_q;
  assign rd_bar     = rd_bar_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ad7864_rd_seq.sv
// Scoreboard bench for ad7864_rd_seq: default 4x4 instance plus a 2x1 instance.
module tb_ad7864_rd_seq;

  localparam int NCHIP  = 4;
  localparam int NCH    = 4;
  localparam int NWORD  = NCHIP * NCH;
  localparam int RD_LOW = 3;
`ifdef AD7864_RD_SEQ_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        busy = 1'b0;
  logic [11:0] db = 12'h000;
  logic [3:0]  cs_bar;
  logic        rd_bar;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_done;
  logic        overrun;

  logic        busy2 = 1'b0;
  logic [11:0] db2 = 12'h5A5;
  logic [1:0]  cs_bar2;
  logic        rd_bar2;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic        ready2 = 1'b1;
  logic        frame_done2;
  logic        overrun2;

  ad7864_rd_seq #(.NCHIP(NCHIP), .NCH(NCH), .RD_LOW_CYC(3), .RD_HIGH_CYC(2)) dut (
    .clkin(clkin), .rst(rst), .busy(busy), .db(db), .cs_bar(cs_bar), .rd_bar(rd_bar),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .overrun(overrun)
  );

  ad7864_rd_seq #(.NCHIP(2), .NCH(1), .RD_LOW_CYC(3), .RD_HIGH_CYC(2)) dut2 (
    .clkin(clkin), .rst(rst), .busy(busy2), .db(db2), .cs_bar(cs_bar2), .rd_bar(rd_bar2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(ready2),
    .frame_done(frame_done2), .overrun(overrun2)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int chip, input int ch, input logic [11:0] d);
    logic [1:0] c;
    logic [1:0] h;
    c = chip[1:0];
    h = ch[1:0];
    return TAG_EN ? {c, h, d} : {4'h0, d};
  endfunction

  // Reference model state: read index within the frame maps to chip/channel.
  logic [15:0] exp_q[$];
  int          rd_idx = 0;
  int          n_reads = 0;
  int          n_xfer = 0;
  int          fd_cnt = 0;
  bit          db_rand = 1'b0;
  logic [11:0] db_fixed = 12'hABC;
  bit          aborted = 1'b0;
  int          ready_mode = 0;
  logic        ovr_exp = 1'b0;

  always @(posedge clkin) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  int         rd_chip, rd_ch, rd_w;
  logic [3:0] cs_exp;

  always @(negedge rd_bar) begin
    if (!rst) begin
      rd_chip = rd_idx / NCH;
      rd_ch   = rd_idx % NCH;
      cs_exp  = ~(4'b0001 << rd_chip);
      check("cs_bar_at_read", 32'(cs_bar), 32'(cs_exp));
      db = db_rand ? 12'($urandom) : db_fixed;
      exp_q.push_back(exp_word(rd_chip, rd_ch, db));
      rd_idx = (rd_idx + 1) % NWORD;
      n_reads++;
      rd_w = 0;
      while (rd_bar === 1'b0 && rd_w < 50) begin
        @(posedge clkin);
        #1;
        rd_w++;
      end
      if (!aborted) check("rd_low_cycles", rd_w, RD_LOW);
    end
  end

  bit          stalled = 1'b0;
  logic [15:0] held;
  logic [15:0] exp_pop;

  always @(negedge clkin) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no word", out_data);
        end else begin
          exp_pop = exp_q.pop_front();
          check("word", out_data, exp_pop);
        end
        n_xfer++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic start_conv();
    @(posedge clkin);
    #1 busy = 1'b1;
    repeat (10) @(posedge clkin);
    #1 busy = 1'b0;
  endtask

  task automatic wait_frame(input int fd0, input int xb, input int nwords);
    int t;
    t = 0;
    while (fd_cnt == fd0 && t < 4000) begin
      @(negedge clkin);
      t++;
    end
    check("frame_done_seen", 32'(fd_cnt != fd0), 1);
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clkin);
      t++;
    end
    repeat (10) @(negedge clkin);
    check("frame_done_once", fd_cnt - fd0, 1);
    check("words_per_frame", n_xfer - xb, nwords);
    check("queue_drained", exp_q.size(), 0);
    check("overrun", overrun, ovr_exp);
    check("idle_cs_bar", cs_bar, 4'hF);
    check("idle_rd_bar", rd_bar, 1);
  endtask

  task automatic wait_rd_idx(input int target);
    int t;
    t = 0;
    while (rd_idx != target && t < 2000) begin
      @(negedge clkin);
      t++;
    end
    check("reached_read", rd_idx, target);
  endtask

  int         fd0, xb, reads0, t2, nr, nw, nf;
  logic       prev_rd2;
  logic [1:0] cs_seen[2];
  logic [15:0] w_seen[2];

  initial begin
    repeat (3) @(posedge clkin);
    #1;
    check("rst_cs_bar", cs_bar, 4'hF);
    check("rst_rd_bar", rd_bar, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cs_bar2", cs_bar2, 2'b11);
    @(negedge clkin) rst = 1'b0;

    // Two chips, one channel each.
    @(posedge clkin);
    #1 busy2 = 1'b1;
    repeat (10) @(posedge clkin);
    #1 busy2 = 1'b0;
    nr = 0; nw = 0; nf = 0; prev_rd2 = 1'b1;
    for (t2 = 0; t2 < 200; t2++) begin
      @(negedge clkin);
      if (prev_rd2 && !rd_bar2) begin
        if (nr < 2) cs_seen[nr] = cs_bar2;
        nr++;
      end
      if (out_valid2) begin
        if (nw < 2) w_seen[nw] = out_data2;
        nw++;
      end
      if (frame_done2) nf++;
      prev_rd2 = rd_bar2;
    end
    check("small_reads", nr, 2);
    check("small_cs0", cs_seen[0], 2'b10);
    check("small_cs1", cs_seen[1], 2'b01);
    check("small_words", nw, 2);
    check("small_word0", w_seen[0], exp_word(0, 0, 12'h5A5));
    check("small_word1", w_seen[1], exp_word(1, 0, 12'h5A5));
    check("small_frame_done", nf, 1);
    check("small_idle_cs", cs_bar2, 2'b11);
    check("small_overrun", overrun2, 0);

    // Frame 1: constant sample, always ready.
    db_fixed = 12'hABC; db_rand = 1'b0; ready_mode = 0;
    fd0 = fd_cnt; xb = n_xfer;
    start_conv();
    wait_frame(fd0, xb, NWORD);

    // Frame 2: consumer stalls after the first word.
    db_fixed = 12'h123; ready_mode = 1;
    fd0 = fd_cnt; xb = n_xfer;
    start_conv();
    t2 = 0;
    while (!out_valid && t2 < 300) begin
      @(negedge clkin);
      t2++;
    end
    check("stall_first_valid", out_valid, 1);
    reads0 = n_reads;
    repeat (20) @(negedge clkin);
    check("stall_no_read", n_reads, reads0);
    check("stall_rd_bar", rd_bar, 1);
    check("stall_word0", out_data, exp_word(0, 0, 12'h123));
    ready_mode = 2;
    wait_frame(fd0, xb, NWORD);

    // Frame 3: random data and back-pressure, new conversion during chip 2.
    db_rand = 1'b1;
    fd0 = fd_cnt; xb = n_xfer;
    start_conv();
    wait_rd_idx(9);
    #1 busy = 1'b1;
    repeat (3) @(posedge clkin);
    #1 busy = 1'b0;
    ovr_exp = 1'b1;
    wait_frame(fd0, xb, NWORD);
    reads0 = n_reads;
    repeat (30) @(negedge clkin);
    check("after_overrun_idle", n_reads, reads0);
    check("overrun_sticky", overrun, 1);

    // Frame 4: reset during chip 1 channel 2.
    ready_mode = 0;
    start_conv();
    wait_rd_idx(7);
    @(posedge clkin);
    #3;
    check("mid_read_rd_low", rd_bar, 0);
    aborted = 1'b1;
    rst = 1'b1;
    #1;
    check("abort_rd_bar", rd_bar, 1);
    check("abort_cs_bar", cs_bar, 4'hF);
    check("abort_out_valid", out_valid, 0);
    check("abort_overrun", overrun, 0);
    repeat (2) @(posedge clkin);
    exp_q.delete();
    rd_idx = 0;
    ovr_exp = 1'b0;
    @(negedge clkin) rst = 1'b0;
    aborted = 1'b0;

    // Frame 5: restarts from chip 0 channel 0.
    ready_mode = 2;
    fd0 = fd_cnt; xb = n_xfer;
    start_conv();
    wait_frame(fd0, xb, NWORD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
